muntjac_tlb: RTL



---
 rtl/muntjac_pkg.sv | 28 ++
 rtl/muntjac_tlb.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/muntjac_pkg.sv
// Shared types for the muntjac memory-management blocks: page permissions
// and the TLB entry layout.
package muntjac_pkg;

    localparam int unsigned VirtAddrLen   = 39;
    localparam int unsigned PhysAddrLen   = 56;
    localparam int unsigned PageOffsetLen = 12;
    localparam int unsigned VpnLen        = VirtAddrLen - PageOffsetLen;  // 27
    localparam int unsigned PpnLen        = PhysAddrLen - PageOffsetLen;  // 44

    // Leaf PTE permissions as returned by the walker; valid=0 means page fault.
    typedef struct packed {
        logic valid;
        logic readable;
        logic writable;
        logic executable;
        logic user;
        logic is_global;
    } page_prot_t;

    typedef struct packed {
        logic              valid;
        logic [VpnLen-1:0] vpn;
        logic [PpnLen-1:0] ppn;
        page_prot_t        perm;
    } tlb_entry_t;

endpackage

// File: rtl/muntjac_tlb.sv
// Fully-associative Sv39 TLB (4 KiB granularity) in front of the page table
// walker. Hits answer one cycle after accept; misses fire a single-cycle walk
// request and forward the walker's answer, caching it when it is not a fault.
//
// Client handshake: a lookup transfers on a rising clock edge where
// req_valid_i && req_ready_o. resp_valid_o is a one-cycle strobe with no
// backpressure. The walker has no ready, so ptw_req_valid_o is a one-cycle
// pulse and at most one walk is in flight.
module muntjac_tlb
    import muntjac_pkg::*;
#(
    parameter int unsigned NumEntries = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [VpnLen-1:0] req_vpn_i,
    output logic              resp_valid_o,
    output logic [PpnLen-1:0] resp_ppn_o,
    output page_prot_t        resp_perm_o,
    input  logic              flush_i,
    output logic              ptw_req_valid_o,
    output logic [VpnLen-1:0] ptw_req_vpn_o,
    input  logic              ptw_resp_valid_i,
    input  logic [PpnLen-1:0] ptw_resp_ppn_i,
    input  page_prot_t        ptw_resp_perm_i
);

    localparam int unsigned IdxW = (NumEntries > 1) ? $clog2(NumEntries) : 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StLookup = 2'd1,
        StWalk   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [VpnLen-1:0] vpn_q;
    logic [IdxW-1:0]   rr_q;
    logic              drop_fill_q, drop_fill_d;
    tlb_entry_t        entries_q [NumEntries];

    logic              accept;
    logic              hit;
    tlb_entry_t        hit_entry;
    logic              all_valid;
    logic [IdxW-1:0]   free_idx;
    logic [IdxW-1:0]   victim_idx;
    logic              install;

    // Tag match against the registered VPN and lowest-index free slot search.
    always_comb begin
        hit       = 1'b0;
        hit_entry = '0;
        all_valid = 1'b1;
        free_idx  = '0;
        for (int i = 0; i < int'(NumEntries); i++) begin
            if (entries_q[i].valid && entries_q[i].vpn == vpn_q) begin
                hit       = 1'b1;
                hit_entry = entries_q[i];
            end
        end
        for (int i = int'(NumEntries) - 1; i >= 0; i--) begin
            if (!entries_q[i].valid) begin
                all_valid = 1'b0;
                free_idx  = IdxW'(i);
            end
        end
        victim_idx = all_valid ? rr_q : free_idx;
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StLookup;
            StLookup: begin
                if (!hit)        state_d = StWalk;
                else if (accept) state_d = StLookup;
                else             state_d = StIdle;
            end
            StWalk:   if (ptw_resp_valid_i) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs: handshake, response mux (entry on hit, walker on fill), walk pulse.
    always_comb begin
        req_ready_o     = 1'b0;
        resp_valid_o    = 1'b0;
        resp_ppn_o      = '0;
        resp_perm_o     = '0;
        ptw_req_valid_o = 1'b0;
        ptw_req_vpn_o   = vpn_q;
        if (!rst_i) begin
            unique case (state_q)
                StIdle: req_ready_o = !flush_i;
                StLookup: begin
                    if (hit) begin
                        resp_valid_o = 1'b1;
                        resp_ppn_o   = hit_entry.ppn;
                        resp_perm_o  = hit_entry.perm;
                        req_ready_o  = !flush_i;
                    end else begin
                        ptw_req_valid_o = 1'b1;
                    end
                end
                StWalk: begin
                    if (ptw_resp_valid_i) begin
                        resp_valid_o = 1'b1;
                        resp_ppn_o   = ptw_resp_ppn_i;
                        resp_perm_o  = ptw_resp_perm_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign accept  = req_valid_i && req_ready_o;
    assign install = (state_q == StWalk) && ptw_resp_valid_i &&
                     ptw_resp_perm_i.valid && !drop_fill_q;

    // A flush while walking poisons the pending fill; it clears when the walk ends.
    always_comb begin
        drop_fill_d = drop_fill_q;
        if (state_q == StWalk) begin
            if (ptw_resp_valid_i) drop_fill_d = 1'b0;
            else if (flush_i)     drop_fill_d = 1'b1;
        end else begin
            drop_fill_d = 1'b0;
        end
    end

    // Entry array, replacement pointer and lookup VPN; flush is applied last so it wins over a fill.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumEntries); i++) begin
                entries_q[i].valid <= 1'b0;
            end
            rr_q        <= '0;
            drop_fill_q <= 1'b0;
            vpn_q       <= '0;
        end else begin
            if (accept) vpn_q <= req_vpn_i;
            drop_fill_q <= drop_fill_d;
            if (install) begin
                entries_q[victim_idx] <= '{valid: 1'b1, vpn: vpn_q,
                                           ppn: ptw_resp_ppn_i, perm: ptw_resp_perm_i};
                if (all_valid) rr_q <= rr_q + IdxW'(1);
            end
            if (flush_i) begin
                for (int i = 0; i < int'(NumEntries); i++) begin
                    entries_q[i].valid <= 1'b0;
                end
            end
        end
    end

endmodule
